// File: rtl/if_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD,
    DISCARD
  } if_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, talks to instruction memory over a
// hold-until-ready handshake and drives the IF/ID register, inserting NOP bubbles.
module if_stage
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hazardStall,
  input  logic        EXE_jumpBranch,
  input  logic [31:0] EXE_target,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ready,
  input  logic [31:0] im_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc
);

  if_state_e   state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] bufpc_q, bufpc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;

  logic        wordValid;
  logic [31:0] wordInst;
  logic [31:0] wordPc;
  logic [31:0] target;

  assign target  = align_word(EXE_target);
  assign im_addr = addr_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    tgt_d     = tgt_q;
    buf_d     = buf_q;
    bufpc_d   = bufpc_q;
    im_req    = 1'b0;
    wordValid = 1'b0;
    wordInst  = NOP_INST;
    wordPc    = 32'h0;

    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
      end

      FETCH: begin
        im_req = 1'b1;
        if (im_ready) begin
          if (EXE_jumpBranch) begin
            addr_d = target;
          end else if (hazardStall) begin
            // Decode cannot take the word yet, so park it until the stall clears.
            buf_d   = im_rdata;
            bufpc_d = addr_q;
            addr_d  = addr_q + 32'd4;
            state_d = HOLD;
          end else begin
            wordValid = 1'b1;
            wordInst  = im_rdata;
            wordPc    = addr_q;
            addr_d    = addr_q + 32'd4;
          end
        end else if (EXE_jumpBranch) begin
          tgt_d   = target;
          state_d = DISCARD;
        end
      end

      HOLD: begin
        if (EXE_jumpBranch) begin
          addr_d  = target;
          state_d = FETCH;
        end else if (!hazardStall) begin
          wordValid = 1'b1;
          wordInst  = buf_q;
          wordPc    = bufpc_q;
          state_d   = FETCH;
        end
      end

      DISCARD: begin
        // The stale request must still complete before the redirect target is issued.
        im_req = 1'b1;
        if (EXE_jumpBranch) begin
          tgt_d = target;
        end
        if (im_ready) begin
          addr_d  = EXE_jumpBranch ? target : tgt_q;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_comb begin
    inst_d = NOP_INST;
    pc_d   = 32'h0;
    if (EXE_jumpBranch) begin
      inst_d = NOP_INST;
      pc_d   = 32'h0;
    end else if (hazardStall) begin
      inst_d = inst_q;
      pc_d   = pc_q;
    end else if (wordValid) begin
      inst_d = wordInst;
      pc_d   = wordPc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      addr_q  <= RESET_PC;
      tgt_q   <= 32'h0;
      buf_q   <= NOP_INST;
      bufpc_q <= 32'h0;
      inst_q  <= NOP_INST;
      pc_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tgt_q   <= tgt_d;
      buf_q   <= buf_d;
      bufpc_q <= bufpc_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
    end
  end

  assign instruction = inst_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: a wait-state memory plus a reference model of the
// fetch rules (held word, stale request, pending target) predicts every output.
module tb_if_stage;
  import if_pkg::*;

  localparam int NUM_CYCLES = 1600;

  logic        clk;
  logic        rst;
  logic        hazardStall;
  logic        EXE_jumpBranch;
  logic [31:0] EXE_target;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready;
  logic [31:0] im_rdata;
  logic [31:0] instruction;
  logic [31:0] pc;

  int checkCount;
  int errorCount;

  // Reference model state
  logic        mBoot;
  logic        mHeldValid;
  logic [31:0] mHeldWord;
  logic [31:0] mHeldPc;
  logic        mStale;
  logic [31:0] mPendTgt;
  logic [31:0] mAddr;
  logic [31:0] mInst;
  logic [31:0] mPc;
  int          memCnt;
  int          memWait;

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .hazardStall   (hazardStall),
    .EXE_jumpBranch(EXE_jumpBranch),
    .EXE_target    (EXE_target),
    .im_req        (im_req),
    .im_addr       (im_addr),
    .im_ready      (im_ready),
    .im_rdata      (im_rdata),
    .instruction   (instruction),
    .pc            (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, observed, expected);
    end
  endtask

  function automatic logic modelReq();
    return !mBoot && !mHeldValid;
  endfunction

  function automatic int newWait(input int cyc);
    if (cyc < 60) return 0;
    else if (cyc < 140) return 2;
    else return $urandom_range(0, 3);
  endfunction

  task automatic modelReset();
    mBoot      = 1'b1;
    mHeldValid = 1'b0;
    mHeldWord  = NOP_INST;
    mHeldPc    = 32'h0;
    mStale     = 1'b0;
    mPendTgt   = 32'h0;
    mAddr      = RESET_PC;
    mInst      = NOP_INST;
    mPc        = 32'h0;
    memCnt     = 0;
    memWait    = 0;
  endtask

  task automatic checkModel(input int cyc);
    string sfx;
    sfx = $sformatf("@%0d", cyc);
    checkOutput({"im_req", sfx}, {31'b0, im_req}, {31'b0, modelReq()});
    checkOutput({"im_addr", sfx}, im_addr, mAddr);
    checkOutput({"instruction", sfx}, instruction, mInst);
    checkOutput({"pc", sfx}, pc, mPc);
  endtask

  task automatic applyStimulus(input int cyc);
    if (modelReq()) begin
      im_ready = (memCnt >= memWait);
      im_rdata = im_ready ? (mAddr | 32'hA000_0000) : $urandom;
    end else begin
      im_ready = 1'($urandom_range(0, 1));
      im_rdata = $urandom;
    end
    if (cyc < 140) begin
      hazardStall    = 1'b0;
      EXE_jumpBranch = 1'b0;
      EXE_target     = $urandom;
    end else begin
      hazardStall    = ($urandom_range(0, 3) == 0);
      EXE_jumpBranch = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) EXE_target = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else EXE_target = $urandom & 32'h0000_0FFF;
    end
  endtask

  // Advance the model across the coming rising edge using the inputs just driven.
  task automatic modelStep(input int cyc);
    logic        req;
    logic        haveWord;
    logic [31:0] tgt;
    logic [31:0] wWord;
    logic [31:0] wPc;
    req      = modelReq();
    tgt      = EXE_target & 32'hFFFF_FFFC;
    haveWord = 1'b0;
    wWord    = NOP_INST;
    wPc      = 32'h0;

    if (mBoot) begin
      mBoot = 1'b0;
    end else if (mHeldValid) begin
      if (EXE_jumpBranch) begin
        mHeldValid = 1'b0;
        mAddr      = tgt;
      end else if (!hazardStall) begin
        haveWord   = 1'b1;
        wWord      = mHeldWord;
        wPc        = mHeldPc;
        mHeldValid = 1'b0;
      end
    end else if (mStale) begin
      if (im_ready) begin
        mAddr  = EXE_jumpBranch ? tgt : mPendTgt;
        mStale = 1'b0;
      end else if (EXE_jumpBranch) begin
        mPendTgt = tgt;
      end
    end else if (im_ready) begin
      if (EXE_jumpBranch) begin
        mAddr = tgt;
      end else if (hazardStall) begin
        mHeldValid = 1'b1;
        mHeldWord  = im_rdata;
        mHeldPc    = mAddr;
        mAddr      = mAddr + 32'd4;
      end else begin
        haveWord = 1'b1;
        wWord    = im_rdata;
        wPc      = mAddr;
        mAddr    = mAddr + 32'd4;
      end
    end else if (EXE_jumpBranch) begin
      mPendTgt = tgt;
      mStale   = 1'b1;
    end

    if (EXE_jumpBranch) begin
      mInst = NOP_INST;
      mPc   = 32'h0;
    end else if (!hazardStall) begin
      mInst = haveWord ? wWord : NOP_INST;
      mPc   = haveWord ? wPc : 32'h0;
    end

    if (req) begin
      if (im_ready) begin
        memCnt  = 0;
        memWait = newWait(cyc);
      end else begin
        memCnt++;
      end
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req"}, {31'b0, im_req}, 32'h0);
    checkOutput({tag, "_addr"}, im_addr, RESET_PC);
    checkOutput({tag, "_inst"}, instruction, NOP_INST);
    checkOutput({tag, "_pc"}, pc, 32'h0);
  endtask

  initial begin
    checkCount     = 0;
    errorCount     = 0;
    rst            = 1'b0;
    hazardStall    = 1'b0;
    EXE_jumpBranch = 1'b0;
    EXE_target     = 32'h0;
    im_ready       = 1'b0;
    im_rdata       = 32'h0;
    modelReset();

    repeat (3) @(negedge clk);
    checkResetValues("initReset");
    rst = 1'b1;

    for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
      if (cyc == 700 || cyc == 1200) begin
        rst = 1'b0;
        #1;
        checkResetValues($sformatf("midReset%0d", cyc));
        modelReset();
        im_ready       = 1'b1;
        im_rdata       = $urandom;
        EXE_jumpBranch = 1'($urandom_range(0, 1));
        hazardStall    = 1'($urandom_range(0, 1));
        repeat (2) @(negedge clk);
        checkResetValues($sformatf("heldReset%0d", cyc));
        rst = 1'b1;
      end
      checkModel(cyc);
      applyStimulus(cyc);
      modelStep(cyc);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage RV32I pipeline. It owns the fetch PC, issues requests to the instruction memory over a hold-until-ready handshake, and drives the IF/ID pipeline register (`instruction`, `pc`) consumed by the decode stage. It honours the decode stage's `hazardStall` hold and the execute stage's `EXE_jumpBranch` redirect and flush. It inserts NOP bubbles whenever no fetched word is available.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP_INST`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`)
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `hazardStall`  in  1  decode holds its instruction; IF/ID must not change
- `EXE_jumpBranch`  in  1  taken jump/branch resolved in EXE this cycle
- `EXE_target`  in  32  redirect address, valid with `EXE_jumpBranch`
- `im_req`  out  1  instruction-memory request
- `im_addr`  out  32  request address, word aligned
- `im_ready`  in  1  response strobe; `im_rdata` valid this cycle
- `im_rdata`  in  32  fetched instruction word
- `instruction`  out  32  IF/ID register: instruction to decode
- `pc`  out  32  IF/ID register: address of `instruction`

## Operation
- Registers:
  - `addr_q`: address of the current or next request; `im_addr` = `addr_q`.
  - `tgt_q`: pending redirect target.
  - `buf_q`: instruction buffer.
  - `bufpc_q`: address of the buffered word.
  - FSM state.
- Handshake:
  - Once `im_req` rises, it stays high and `im_addr` stays stable until a cycle with `im_ready`=1. A request completes in that cycle.
  - `im_ready` in the same cycle `im_req` rises is legal (zero wait).
  - `im_ready` with `im_req`=0 is ignored.
- States:
  - BOOT (reset state): `im_req`=0; go to FETCH unconditionally.
  - FETCH: `im_req`=1.
    - On `im_ready`: `EXE_jumpBranch` → drop data, `addr_q`←`EXE_target`, stay in FETCH.
    - Else `hazardStall` → `buf_q`←`im_rdata`, `bufpc_q`←`addr_q`, `addr_q`+=4, go to HOLD.
    - Else → pass the word to IF/ID, `addr_q`+=4, stay in FETCH.
    - No `im_ready` and `EXE_jumpBranch` → `tgt_q`←`EXE_target`, go to DISCARD.
  - HOLD: `im_req`=0.
    - `EXE_jumpBranch` → drop buffer, `addr_q`←`EXE_target`, go to FETCH.
    - Else `!hazardStall` → IF/ID←buffer, go to FETCH.
  - DISCARD: `im_req`=1 at the stale address.
    - A further `EXE_jumpBranch` overwrites `tgt_q`.
    - On `im_ready`: drop data, `addr_q`←`tgt_q` (or `EXE_target` if it is asserted in the same cycle), go to FETCH.
- IF/ID update priority at each edge:
  1. `EXE_jumpBranch` → `instruction`=`NOP_INST`, `pc`=0.
  2. `hazardStall` → hold.
  3. Word available (FETCH accept or HOLD release) → load the word and its address.
  4. Otherwise → `NOP_INST`, `pc`=0.
- `addr_q` increments wrap modulo 2^32. Bits [1:0] of `EXE_target` are forced to 0.

## Timing
- Reset values:
  - state BOOT, `im_req`=0, `im_addr`=`RESET_PC`
  - `instruction`=`NOP_INST`, `pc`=0
  - `buf_q`=`NOP_INST`, `bufpc_q`=0, `tgt_q`=0
- First `im_req` occurs in the second cycle after `rst` deasserts, at address `RESET_PC`.
- Zero-wait memory: an accepted word appears on `instruction` one edge later. Throughput is one instruction per cycle.
- Redirect at cycle t with a request completing at t: `im_addr`=target at t+1.
- Redirect with the request still outstanding: target is issued the cycle after the stale `im_ready`.
- N-wait memory: one instruction per N+1 cycles; bubbles fill the gaps.
- Stall released at t (HOLD): the buffered word is in IF/ID at t+1, and the next request is issued at t+1.
- `EXE_jumpBranch` and `hazardStall` together: the flush wins and the buffer is dropped.
- `rst` asserted mid-request: everything returns to reset values immediately. A memory response after reset is ignored until FETCH is entered.

## Structure
- Package `if_pkg`:
  - `if_state_e` enum: BOOT, FETCH, HOLD, DISCARD
  - `NOP_INST` and `RESET_PC` default constants
- Single module; no sub-module is needed.

## Test plan
- Reset release, zero-wait memory returning `addr`|32'hA0000000 → `im_addr` sequence 0,4,8,…; `pc`/`instruction` follow one cycle behind with no bubbles.
- Memory with 2 wait states → each word held on `im_addr` for 3 cycles; two `NOP_INST` bubbles between consecutive instructions.
- `hazardStall` for 3 cycles while the word at 0x10 is accepted → IF/ID frozen; `im_req`=0; after release `pc`=0x10, then `im_addr`=0x14.
- `EXE_jumpBranch`, target 0x200, coincident with `im_ready` at 0x8 → IF/ID becomes NOP/0; next `im_addr`=0x200; word 0x8 never reaches decode.
- `EXE_jumpBranch`, target 0x300, while a 3-wait request at 0x20 is outstanding → `im_addr` stays 0x20 until `im_ready`, its data is dropped, then `im_addr`=0x300.
- `hazardStall` and `EXE_jumpBranch` together in HOLD → buffer discarded, IF/ID=NOP, `im_addr`=target; `rst` pulse mid-request → all outputs return to reset values.
